// File: rtl/gauss_row_filter.sv
// Horizontal pass of a separable Gaussian blur: sliding window over a raster line with edge
// replication on both sides, 3-stage multiply / sum / round-saturate pipeline.
module gauss_row_filter #(
  parameter int unsigned PW         = 8,
  parameter int unsigned CW         = 9,
  parameter int unsigned RADI       = 9,
  parameter int unsigned NORM_SHIFT = 8,
  parameter int unsigned AW         = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coef_we_i,
  input  logic [AW-1:0] coef_addr_i,
  input  logic [CW-1:0] coef_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_pix_i,
  input  logic          in_sol_i,
  input  logic          in_eol_i,
  output logic          out_valid_o,
  output logic [PW-1:0] out_pix_o,
  output logic          out_sol_o,
  output logic          out_eol_o,
  output logic          line_err_o
);

  localparam int unsigned TAPS = 2 * RADI + 1;
  localparam int unsigned PrW  = PW + CW;
  localparam int unsigned AccW = PW + CW + $clog2(TAPS);
  localparam int unsigned RndW = AccW + 1;
  localparam int unsigned CntW = $clog2(RADI + 1);
  localparam logic [CntW-1:0] RadiM1 = CntW'(RADI - 1);
  localparam logic [RndW-1:0] MaxPix = RndW'((2 ** PW) - 1);
  localparam logic [RndW-1:0] Half   = RndW'(1) << (NORM_SHIFT - 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   last_q, last_d;
  logic [PW-1:0]   win_q [TAPS];
  logic [PW-1:0]   win_d [TAPS];
  logic [CW-1:0]   coef_q [TAPS];
  logic            iss_q, iss_d, iss_sol_q, iss_sol_d, iss_eol_q, iss_eol_d;
  logic            err_q, err_d;

  logic [PrW-1:0]  prod_q [TAPS];
  logic [PrW-1:0]  prod_d [TAPS];
  logic            v1_q, sol1_q, eol1_q;
  logic [AccW-1:0] sum_q, sum_d;
  logic            v2_q, sol2_q, eol2_q;
  logic [PW-1:0]   pix_q, pix_d;
  logic            v3_q, sol3_q, eol3_q;

  logic            xfer, do_load, do_shift;
  logic [PW-1:0]   shift_pix;
  logic [RndW-1:0] rnd, shf;

  assign in_ready_o = (state_q != StFlush);
  assign xfer       = in_valid_i & in_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    iss_d     = 1'b0;
    iss_sol_d = 1'b0;
    iss_eol_d = 1'b0;
    err_d     = 1'b0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    shift_pix = in_pix_i;
    unique case (state_q)
      StIdle: begin
        if (xfer && in_sol_i) begin
          if (in_eol_i) begin
            err_d = 1'b1;
          end else begin
            do_load = 1'b1;
            cnt_d   = '0;
            state_d = StFill;
          end
        end
      end
      StFill, StRun: begin
        if (xfer) begin
          if (in_sol_i) begin
            // Abandon the current line; a one-pixel replacement line is itself invalid.
            err_d = 1'b1;
            if (in_eol_i) begin
              state_d = StIdle;
            end else begin
              do_load = 1'b1;
              cnt_d   = '0;
              state_d = StFill;
            end
          end else if (state_q == StFill) begin
            do_shift = 1'b1;
            if (cnt_q == RadiM1) begin
              iss_d     = 1'b1;
              iss_sol_d = 1'b1;
              if (in_eol_i) begin
                last_d  = in_pix_i;
                cnt_d   = '0;
                state_d = StFlush;
              end else begin
                state_d = StRun;
              end
            end else if (in_eol_i) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            do_shift = 1'b1;
            iss_d    = 1'b1;
            if (in_eol_i) begin
              last_d  = in_pix_i;
              cnt_d   = '0;
              state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        do_shift  = 1'b1;
        shift_pix = last_q;
        iss_d     = 1'b1;
        if (cnt_q == RadiM1) begin
          iss_eol_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      win_d[k] = win_q[k];
    end
    if (do_load) begin
      for (int k = 0; k < TAPS; k++) begin
        win_d[k] = in_pix_i;
      end
    end else if (do_shift) begin
      for (int k = 0; k < TAPS - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[TAPS-1] = shift_pix;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = PrW'(win_q[k]) * PrW'(coef_q[k]);
    end
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_d = sum_d + AccW'(prod_q[k]);
    end
    rnd   = RndW'(sum_q) + Half;
    shf   = rnd >> NORM_SHIFT;
    pix_d = (shf > MaxPix) ? '1 : shf[PW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= '0;
      iss_q     <= 1'b0;
      iss_sol_q <= 1'b0;
      iss_eol_q <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= (k == RADI) ? CW'(2 ** NORM_SHIFT) : '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      iss_q     <= iss_d;
      iss_sol_q <= iss_sol_d;
      iss_eol_q <= iss_eol_d;
      err_q     <= err_d;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= win_d[k];
      end
      // Out-of-range addresses match no tap and are dropped.
      if (state_q == StIdle && coef_we_i) begin
        for (int k = 0; k < TAPS; k++) begin
          if (coef_addr_i == AW'(k)) coef_q[k] <= coef_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= '0;
      end
      v1_q   <= 1'b0;
      sol1_q <= 1'b0;
      eol1_q <= 1'b0;
      sum_q  <= '0;
      v2_q   <= 1'b0;
      sol2_q <= 1'b0;
      eol2_q <= 1'b0;
      pix_q  <= '0;
      v3_q   <= 1'b0;
      sol3_q <= 1'b0;
      eol3_q <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= prod_d[k];
      end
      v1_q   <= iss_q;
      sol1_q <= iss_sol_q;
      eol1_q <= iss_eol_q;
      sum_q  <= sum_d;
      v2_q   <= v1_q;
      sol2_q <= sol1_q;
      eol2_q <= eol1_q;
      pix_q  <= pix_d;
      v3_q   <= v2_q;
      sol3_q <= sol2_q;
      eol3_q <= eol2_q;
    end
  end

  assign out_valid_o = v3_q;
  assign out_pix_o   = pix_q;
  assign out_sol_o   = sol3_q & v3_q;
  assign out_eol_o   = eol3_q & v3_q;
  assign line_err_o  = err_q;

endmodule

// File: tb/tb_gauss_row_filter.sv
// Bench for gauss_row_filter (RADI=2): table vectors, hand sequences for line errors and
// mid-flush reset, and random lines checked against a clamp-and-convolve reference.
module tb_gauss_row_filter;

  localparam int RADI = 2;
  localparam int TAPS = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coef_we;
  logic [4:0] coef_addr;
  logic [8:0] coef_data;
  logic       in_valid, in_ready, in_sol, in_eol;
  logic [7:0] in_pix;
  logic       out_valid, out_sol, out_eol, line_err;
  logic [7:0] out_pix;

  gauss_row_filter #(.PW(8), .CW(9), .RADI(RADI), .NORM_SHIFT(8), .AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_we_i  (coef_we),
    .coef_addr_i(coef_addr),
    .coef_data_i(coef_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_pix_i   (in_pix),
    .in_sol_i   (in_sol),
    .in_eol_i   (in_eol),
    .out_valid_o(out_valid),
    .out_pix_o  (out_pix),
    .out_sol_o  (out_sol),
    .out_eol_o  (out_eol),
    .line_err_o (line_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pix;
    logic       sol;
    logic       eol;
  } out_t;

  typedef struct packed {
    logic [4:0][8:0] coef;
    logic [4:0][7:0] pix;
    logic [4:0][7:0] exp;
  } vec_t;

  out_t got[$];
  int   got_cyc[$];
  out_t exp_q[$];
  int   line_pix[$];
  int   cm[TAPS];
  int   rd = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  int   rdy_low = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      got.push_back({out_pix, out_sol, out_eol});
      got_cyc.push_back(cyc);
    end
    if (line_err) err_cnt++;
    if (!in_ready) rdy_low++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: clamp indices to the line, convolve, round half-up, saturate.
  function automatic int ref_pix(input int x);
    int acc, idx, n, r;
    n   = line_pix.size();
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      idx = x + k - RADI;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      acc += cm[k] * line_pix[idx];
    end
    r = (acc + 128) >> 8;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic add_exp(input int n_out, input bit with_eol);
    for (int x = 0; x < n_out; x++) begin
      exp_q.push_back({8'(ref_pix(x)), x == 0, with_eol && (x == n_out - 1)});
    end
  endtask

  task automatic push(input int p, input bit s, input bit e);
    int g;
    in_valid = 1'b1;
    in_pix   = 8'(p);
    in_sol   = s;
    in_eol   = e;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("push_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic send_line(input int gap, input bit with_eol);
    int n;
    n = line_pix.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) begin
        @(posedge clk); #1;
      end
      push(line_pix[i], i == 0, with_eol && (i == n - 1));
      if (i == RADI) acc_cyc = cyc;
    end
  endtask

  task automatic write_coefs();
    for (int k = 0; k < TAPS; k++) begin
      coef_we   = 1'b1;
      coef_addr = 5'(k);
      coef_data = 9'(cm[k]);
      @(posedge clk); #1;
    end
    coef_addr = 5'($urandom_range(TAPS, 31));
    coef_data = 9'($urandom);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic check_outs(input string name);
    int n, g;
    n = exp_q.size();
    g = 0;
    while (got.size() - rd < n && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (8) @(posedge clk);
    #1;
    chk({name, "_count"}, got.size() - rd, n);
    for (int i = 0; i < n && rd + i < got.size(); i++) begin
      chk($sformatf("%s_pix%0d", name, i), int'(got[rd+i].pix), int'(exp_q[i].pix));
      chk($sformatf("%s_sol%0d", name, i), int'(got[rd+i].sol), int'(exp_q[i].sol));
      chk($sformatf("%s_eol%0d", name, i), int'(got[rd+i].eol), int'(exp_q[i].eol));
    end
    rd = got.size();
    exp_q.delete();
  endtask

  task automatic rand_line(input string name, input int w);
    line_pix.delete();
    for (int i = 0; i < w; i++) line_pix.push_back(int'($urandom_range(0, 255)));
    send_line(2, 1'b1);
    add_exp(w, 1'b1);
    check_outs(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int r0, e0, l0, n0;
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_pix = '0; in_sol = 1'b0; in_eol = 1'b0;

    for (int k = 0; k < TAPS; k++) begin
      tbl[0].coef[k] = (k == RADI) ? 9'd256 : 9'd0;
      tbl[0].pix[k]  = 8'(10 * (k + 1));
      tbl[0].exp[k]  = 8'(10 * (k + 1));
      tbl[2].coef[k] = 9'd511;
      tbl[2].pix[k]  = 8'd255;
      tbl[2].exp[k]  = 8'd255;
      tbl[1].pix[k]  = 8'(10 * (k + 1));
    end
    tbl[1].coef = {9'd16, 9'd64, 9'd96, 9'd64, 9'd16};
    tbl[1].exp  = {8'd46, 8'd39, 8'd30, 8'd21, 8'd14};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_line_err", int'(line_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Entry 0 runs on reset-default (identity) coefficients.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < TAPS; k++) cm[k] = int'(tbl[t].coef[k]);
      if (t > 0) write_coefs();
      line_pix.delete();
      for (int k = 0; k < TAPS; k++) line_pix.push_back(int'(tbl[t].pix[k]));
      l0 = rdy_low;
      r0 = rd;
      send_line(0, 1'b1);
      for (int k = 0; k < TAPS; k++) begin
        exp_q.push_back({tbl[t].exp[k], k == 0, k == TAPS - 1});
      end
      check_outs($sformatf("table%0d", t));
      chk($sformatf("table%0d_ready_low", t), rdy_low - l0, 2);
      if (t == 0 && got_cyc.size() > r0) chk("first_latency", got_cyc[r0] - acc_cyc, 3);
    end

    // Short line (W=2) and single sol&eol pixel: error pulses, no outputs.
    e0 = err_cnt; n0 = got.size();
    push(77, 1'b1, 1'b0);
    push(88, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("short_err", err_cnt - e0, 1);
    chk("short_outs", got.size() - n0, 0);
    push(5, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("single_err", err_cnt - e0, 2);
    chk("single_outs", got.size() - n0, 0);
    chk("short_idle_ready", int'(in_ready), 1);
    rd = got.size();
    rand_line("after_short", 6);

    // Coefficient write while in RUN must be ignored.
    cm = '{16, 64, 96, 64, 16};
    write_coefs();
    line_pix.delete();
    for (int i = 0; i < 6; i++) line_pix.push_back(int'($urandom_range(0, 255)));
    push(line_pix[0], 1'b1, 1'b0);
    push(line_pix[1], 1'b0, 1'b0);
    push(line_pix[2], 1'b0, 1'b0);
    coef_we = 1'b1; coef_addr = 5'd2; coef_data = 9'd0;
    push(line_pix[3], 1'b0, 1'b0);
    coef_we = 1'b0;
    push(line_pix[4], 1'b0, 1'b0);
    push(line_pix[5], 1'b0, 1'b1);
    add_exp(6, 1'b1);
    check_outs("run_coef_we");

    // sol mid-line: 4-pixel line abandoned (2 outputs already issued), new line follows.
    e0 = err_cnt;
    line_pix.delete();
    for (int i = 0; i < 4; i++) line_pix.push_back(int'($urandom_range(0, 255)));
    send_line(0, 1'b0);
    add_exp(4 - RADI, 1'b0);
    line_pix.delete();
    for (int i = 0; i < 5; i++) line_pix.push_back(int'($urandom_range(0, 255)));
    send_line(1, 1'b1);
    add_exp(5, 1'b1);
    check_outs("mid_sol");
    chk("mid_sol_err", err_cnt - e0, 1);

    // Reset asserted while in FLUSH.
    line_pix.delete();
    for (int i = 0; i < 5; i++) line_pix.push_back(10 * (i + 1));
    send_line(0, 1'b1);
    n0 = got.size();
    chk("pre_rst_flush_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("flush_rst_out_valid", int'(out_valid), 0);
    chk("flush_rst_out_pix", int'(out_pix), 0);
    chk("flush_rst_in_ready", int'(in_ready), 1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_rst_no_outs", got.size() - n0, 0);
    rd = got.size();
    cm = '{0, 0, 256, 0, 0};
    send_line(0, 1'b1);
    add_exp(5, 1'b1);
    check_outs("post_rst_identity");

    // Random coefficient sets and line widths, including the minimum width RADI+1.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < TAPS; k++) cm[k] = int'($urandom_range(0, 511));
      write_coefs();
      rand_line($sformatf("rand%0d", t), (t == 0) ? RADI + 1 : int'($urandom_range(3, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
